// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - Keccak mode, rate/suffix constants and absorb-padder state types
package keccak_pkg;

  typedef enum logic [1:0] {SHA3_256, SHA3_512, SHAKE128, SHAKE256} keccak_mode;

  localparam logic [7:0] RATE_BYTES_SHA3_256 = 8'd136;
  localparam logic [7:0] RATE_BYTES_SHA3_512 = 8'd72;
  localparam logic [7:0] RATE_BYTES_SHAKE128 = 8'd168;
  localparam logic [7:0] RATE_BYTES_SHAKE256 = 8'd136;

  localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

  typedef enum logic [1:0] {ABSORB, EMIT, PAD_EXTRA} absorb_state_t;

  function automatic logic [7:0] rate_bytes(input keccak_mode m);
    case (m)
      SHA3_256: return RATE_BYTES_SHA3_256;
      SHA3_512: return RATE_BYTES_SHA3_512;
      SHAKE128: return RATE_BYTES_SHAKE128;
      default:  return RATE_BYTES_SHAKE256;
    endcase
  endfunction

  function automatic logic [7:0] suffix_byte(input keccak_mode m);
    return (m == SHAKE128 || m == SHAKE256) ? SUFFIX_SHAKE : SUFFIX_SHA3;
  endfunction

endpackage

// File: rtl/keccak_byte_pack.sv
// rtl/keccak_byte_pack.sv - combinational write of n_i input bytes into a block buffer at byte offset off_i
module keccak_byte_pack
  import keccak_pkg::*;
#(
  parameter int DWIDTH         = 256,
  parameter int MAX_RATE_BYTES = 168,
  parameter int CNT_WIDTH      = 8
) (
  input  logic [MAX_RATE_BYTES*8-1:0] buf_i,
  input  logic [DWIDTH-1:0]           data_i,
  input  logic [CNT_WIDTH-1:0]        n_i,
  input  logic [CNT_WIDTH-1:0]        off_i,
  output logic [MAX_RATE_BYTES*8-1:0] buf_o
);

  localparam int KW = DWIDTH / 8;
  localparam int LW = (KW > 1) ? $clog2(KW) : 1;

  logic [LW-1:0] lane;

  always_comb begin
    buf_o = buf_i;
    lane  = '0;
    for (int i = 0; i < MAX_RATE_BYTES; i++) begin
      if (i >= int'(off_i) && i < int'(off_i) + int'(n_i)) begin
        lane = LW'(i - int'(off_i));
        buf_o[i*8 +: 8] = data_i[{lane, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/keccak_absorb_padder.sv
// rtl/keccak_absorb_padder.sv - packs keep-qualified beats into rate blocks with domain suffix and pad10*1
// Optional block/message counters enabled by KECCAK_ABSORB_STATS_EN.
module keccak_absorb_padder
  import keccak_pkg::*;
#(
  parameter int DWIDTH         = 256,
  parameter int MAX_RATE_BYTES = 168,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  keccak_mode                  mode,
  input  logic [DWIDTH-1:0]           s_data,
  input  logic [DWIDTH/8-1:0]         s_keep,
  input  logic                        s_last,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [MAX_RATE_BYTES*8-1:0] blk_data,
  output logic [7:0]                  blk_rate_bytes,
  output logic                        blk_last,
  output logic                        blk_valid,
  input  logic                        blk_ready
`ifdef KECCAK_ABSORB_STATS_EN
  ,
  output logic [31:0]                 blk_cnt,
  output logic [15:0]                 msg_cnt
`endif
);

  localparam int KW = DWIDTH / 8;
  localparam int BW = MAX_RATE_BYTES * 8;

  absorb_state_t          state_q, state_d;
  logic [BW-1:0]          buf_q, buf_d;
  logic [CNT_WIDTH-1:0]   fill_q, fill_d;
  keccak_mode             mode_q, mode_d;
  logic                   in_msg_q, in_msg_d;
  logic                   last_q, last_d;
  logic                   extra_q, extra_d;
  logic                   copy_q, copy_d;
  logic [DWIDTH-1:0]      carry_q, carry_d;
  logic [CNT_WIDTH-1:0]   carry_n_q, carry_n_d;
  logic                   carry_last_q, carry_last_d;

  keccak_mode             cur_mode;
  logic [CNT_WIDTH-1:0]   rate, space, n_keep, fill_n;
  logic [7:0]             sfx;
  logic                   accept;
  logic [DWIDTH-1:0]      pk_data;
  logic [CNT_WIDTH-1:0]   pk_n, pk_off;
  logic [BW-1:0]          pk_out;

  function automatic logic [BW-1:0] apply_pad(input logic [BW-1:0] b, input logic [CNT_WIDTH-1:0] p,
                                              input logic [CNT_WIDTH-1:0] r, input logic [7:0] s);
    logic [BW-1:0]        o;
    logic [CNT_WIDTH-1:0] top;
    o   = b;
    top = r - CNT_WIDTH'(1);
    o[{p, 3'b000} +: 8]   = o[{p, 3'b000} +: 8] ^ s;
    o[{top, 3'b000} +: 8] = o[{top, 3'b000} +: 8] ^ 8'h80;
    return o;
  endfunction

  // Mode is taken live only for the first beat; afterwards the latched copy rules.
  assign cur_mode = in_msg_q ? mode_q : mode;
  assign rate     = CNT_WIDTH'(rate_bytes(cur_mode));
  assign sfx      = suffix_byte(cur_mode);
  assign space    = rate - fill_q;
  assign fill_n   = fill_q + n_keep;

  assign s_ready        = !rst && (state_q == ABSORB) && !copy_q;
  assign accept         = s_valid && s_ready;
  assign blk_valid      = (state_q == EMIT) || (state_q == PAD_EXTRA);
  assign blk_last       = last_q;
  assign blk_data       = buf_q;
  assign blk_rate_bytes = rate_bytes(mode_q);

  // Keep bits above the first zero are ignored.
  always_comb begin
    n_keep = '0;
    for (int i = 0; i < KW; i++) begin
      if (s_keep[i] && n_keep == CNT_WIDTH'(i)) n_keep = CNT_WIDTH'(i + 1);
    end
  end

  always_comb begin
    if (copy_q) begin
      pk_data = carry_q;
      pk_n    = carry_n_q;
      pk_off  = '0;
    end else begin
      pk_data = s_data;
      pk_n    = (n_keep > space) ? space : n_keep;
      pk_off  = fill_q;
    end
  end

  keccak_byte_pack #(
    .DWIDTH        (DWIDTH),
    .MAX_RATE_BYTES(MAX_RATE_BYTES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_pack (
    .buf_i (buf_q),
    .data_i(pk_data),
    .n_i   (pk_n),
    .off_i (pk_off),
    .buf_o (pk_out)
  );

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    fill_d       = fill_q;
    mode_d       = mode_q;
    in_msg_d     = in_msg_q;
    last_d       = last_q;
    extra_d      = extra_q;
    copy_d       = copy_q;
    carry_d      = carry_q;
    carry_n_d    = carry_n_q;
    carry_last_d = carry_last_q;
    case (state_q)
      ABSORB: begin
        if (copy_q) begin
          copy_d       = 1'b0;
          carry_n_d    = '0;
          carry_last_d = 1'b0;
          buf_d        = pk_out;
          fill_d       = carry_n_q;
          if (carry_last_q) begin
            buf_d   = apply_pad(pk_out, carry_n_q, rate, sfx);
            last_d  = 1'b1;
            state_d = EMIT;
          end
        end else if (accept) begin
          if (!in_msg_q) begin
            in_msg_d = 1'b1;
            mode_d   = mode;
          end
          buf_d = pk_out;
          if (n_keep > space) begin
            // Overflowing bytes wait in the carry register until the block is taken.
            carry_d      = s_data >> {space, 3'b000};
            carry_n_d    = n_keep - space;
            carry_last_d = s_last;
            last_d       = 1'b0;
            state_d      = EMIT;
          end else begin
            fill_d = fill_n;
            if (fill_n == rate) begin
              last_d  = 1'b0;
              extra_d = s_last;
              state_d = EMIT;
            end else if (s_last) begin
              buf_d   = apply_pad(pk_out, fill_n, rate, sfx);
              last_d  = 1'b1;
              state_d = EMIT;
            end
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          buf_d  = '0;
          fill_d = '0;
          if (extra_q) begin
            extra_d = 1'b0;
            buf_d   = apply_pad('0, '0, rate, sfx);
            last_d  = 1'b1;
            state_d = PAD_EXTRA;
          end else begin
            state_d = ABSORB;
            copy_d  = (carry_n_q != '0);
            if (last_q) begin
              in_msg_d = 1'b0;
              last_d   = 1'b0;
            end
          end
        end
      end
      PAD_EXTRA: begin
        if (blk_ready) begin
          buf_d    = '0;
          in_msg_d = 1'b0;
          last_d   = 1'b0;
          state_d  = ABSORB;
        end
      end
      default: state_d = ABSORB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ABSORB;
      buf_q        <= '0;
      fill_q       <= '0;
      mode_q       <= SHA3_256;
      in_msg_q     <= 1'b0;
      last_q       <= 1'b0;
      extra_q      <= 1'b0;
      copy_q       <= 1'b0;
      carry_q      <= '0;
      carry_n_q    <= '0;
      carry_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      mode_q       <= mode_d;
      in_msg_q     <= in_msg_d;
      last_q       <= last_d;
      extra_q      <= extra_d;
      copy_q       <= copy_d;
      carry_q      <= carry_d;
      carry_n_q    <= carry_n_d;
      carry_last_q <= carry_last_d;
    end
  end

`ifdef KECCAK_ABSORB_STATS_EN
  logic [31:0] blk_cnt_q;
  logic [15:0] msg_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
      msg_cnt_q <= '0;
    end else if (blk_valid && blk_ready) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
      if (blk_last) msg_cnt_q <= msg_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
  assign msg_cnt = msg_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_absorb_padder.sv
// tb/tb_keccak_absorb_padder.sv - randomized bench for keccak_absorb_padder against a byte-level padding model
module tb_keccak_absorb_padder;
  import keccak_pkg::*;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int RB = 168;
  localparam int BW = RB * 8;

  logic              clk = 1'b0;
  logic              rst;
  keccak_mode        mode;
  logic [DW-1:0]     s_data;
  logic [KW-1:0]     s_keep;
  logic              s_last, s_valid, s_ready;
  logic [BW-1:0]     blk_data;
  logic [7:0]        blk_rate_bytes;
  logic              blk_last, blk_valid, blk_ready;

  always #5 clk = ~clk;

  keccak_absorb_padder dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .s_data        (s_data),
    .s_keep        (s_keep),
    .s_last        (s_last),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .blk_data      (blk_data),
    .blk_rate_bytes(blk_rate_bytes),
    .blk_last      (blk_last),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready)
  );

  typedef struct {
    logic [BW-1:0] d;
    logic          last;
    logic [7:0]    rate;
  } blk_t;

  blk_t          exp_q[$];
  logic [7:0]    msg_buf[$];
  int            n_pass = 0;
  int            n_checks = 0;
  int            bp_left = 0;
  logic          hold_v = 1'b0;
  logic [BW-1:0] hold_d;
  logic          hold_last;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int model_rate(input keccak_mode m);
    case (m)
      SHA3_256: return 136;
      SHA3_512: return 72;
      SHAKE128: return 168;
      default:  return 136;
    endcase
  endfunction

  function automatic logic [7:0] model_sfx(input keccak_mode m);
    return (m == SHAKE128 || m == SHAKE256) ? 8'h1F : 8'h06;
  endfunction

  // Standard sponge padding over the whole message, then cut into rate-sized blocks.
  task automatic push_expected(input keccak_mode m);
    int         r, len, nb;
    logic [7:0] pb[];
    blk_t       e;
    r   = model_rate(m);
    len = msg_buf.size();
    nb  = len / r + 1;
    pb  = new[nb * r];
    foreach (pb[i]) pb[i] = 8'h00;
    for (int i = 0; i < len; i++) pb[i] = msg_buf[i];
    pb[len]        = pb[len] ^ model_sfx(m);
    pb[nb * r - 1] = pb[nb * r - 1] ^ 8'h80;
    for (int k = 0; k < nb; k++) begin
      e.d = '0;
      for (int i = 0; i < r; i++) e.d[i*8 +: 8] = pb[k*r + i];
      e.last = (k == nb - 1);
      e.rate = 8'(r);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_msg(input int len);
    msg_buf.delete();
    for (int i = 0; i < len; i++) msg_buf.push_back(8'($urandom));
  endtask

  // chunk==0 picks random beat sizes; abort3 sends three full beats with no s_last and no expectation.
  task automatic send_msg(input keccak_mode m, input int chunk, input bit abort3);
    int          len, idx, n, rem, beats, waitc;
    logic [31:0] g;
    logic [1:0]  mr;
    len = msg_buf.size();
    if (!abort3) push_expected(m);
    idx   = 0;
    beats = 0;
    do begin
      rem = len - idx;
      if (abort3) n = KW;
      else if (chunk > 0) n = (rem < chunk) ? rem : chunk;
      else n = (rem == 0) ? 0 : $urandom_range(1, (rem < KW) ? rem : KW);
      for (int j = 0; j < KW; j++) s_data[j*8 +: 8] = (j < n) ? msg_buf[idx + j] : 8'($urandom);
      if (n >= KW) s_keep = '1;
      else begin
        g      = $urandom;
        s_keep = ((32'd1 << n) - 32'd1) | (g << (n + 1));
      end
      s_last = abort3 ? 1'b0 : (idx + n == len);
      mr     = 2'($urandom_range(0, 3));
      mode   = (beats == 0) ? m : keccak_mode'(mr);
      s_valid = 1'b1;
      waitc = 0;
      while (!s_ready && waitc < 500) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 500) check_eq("beat_accept_timeout", 0, 1);
      @(negedge clk);
      idx += n;
      beats++;
    end while (abort3 ? (beats < 3) : (idx < len));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 3000) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic r;
    blk_t e;
    if (rst) begin
      blk_ready = 1'b0;
      hold_v    = 1'b0;
    end else begin
      if (hold_v) begin
        check_eq("hold_valid", blk_valid, 1);
        check_eq("hold_data", blk_data, hold_d);
        check_eq("hold_last", blk_last, hold_last);
      end
      if (blk_valid) check_eq("s_ready_low_while_valid", s_ready, 0);
      if (bp_left > 0 && blk_valid) begin
        r = 1'b0;
        bp_left--;
      end else begin
        r = ($urandom_range(0, 9) < 7);
      end
      blk_ready = r;
      if (blk_valid && r) begin
        if (exp_q.size() == 0) check_eq("unexpected_block", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("blk_data", blk_data, e.d);
          check_eq("blk_last", blk_last, e.last);
          check_eq("blk_rate", blk_rate_bytes, e.rate);
        end
      end
      hold_v    = blk_valid && !r;
      hold_d    = blk_data;
      hold_last = blk_last;
    end
  end

  initial begin
    logic [1:0] mr;
    rst       = 1'b1;
    blk_ready = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_keep    = '0;
    s_data    = '0;
    mode      = SHA3_256;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_blk_valid", blk_valid, 0);
    check_eq("rst_blk_last", blk_last, 0);
    check_eq("rst_blk_data", blk_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_s_ready", s_ready, 1);

    msg_buf = '{8'h61, 8'h62, 8'h63};
    send_msg(SHA3_256, 0, 1'b0);
    wait_drain();

    msg_buf.delete();
    send_msg(SHAKE128, 0, 1'b0);
    wait_drain();

    rand_msg(71);  send_msg(SHA3_512, 32, 1'b0);
    rand_msg(136); send_msg(SHA3_256, 32, 1'b0);
    rand_msg(150); send_msg(SHA3_256, 32, 1'b0);
    rand_msg(168); send_msg(SHAKE128, 32, 1'b0);
    rand_msg(135); send_msg(SHAKE256, 0, 1'b0);
    rand_msg(72);  send_msg(SHA3_512, 0, 1'b0);
    wait_drain();

    bp_left = 10;
    rand_msg(40);
    send_msg(SHA3_256, 0, 1'b0);
    wait_drain();

    rand_msg(96);
    send_msg(SHAKE256, 32, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("midmsg_rst_blk_valid", blk_valid, 0);
    check_eq("midmsg_rst_s_ready", s_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midmsg_post_rst_s_ready", s_ready, 1);
    check_eq("midmsg_post_rst_blk_valid", blk_valid, 0);
    @(negedge clk);
    msg_buf = '{8'h61, 8'h62, 8'h63};
    send_msg(SHA3_256, 0, 1'b0);
    wait_drain();

    for (int k = 0; k < 40; k++) begin
      mr = 2'($urandom_range(0, 3));
      rand_msg($urandom_range(0, 400));
      send_msg(keccak_mode'(mr), ($urandom_range(0, 1) == 1) ? 32 : 0, 1'b0);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
